sig_conditioner: RTL

Input front end for the frequency meter. It sits directly upstream of the period/edge counter and conditions the raw external `sig` pin. The pin is synchronised into the `clk` domain, narrow glitches are rejected with a persistence filter, and single-cycle rise/fall strobes are emitted. It also flags loss of signal when no rising edge arrives within a timeout measured in 10 us ticks.

---
 rtl/sig_conditioner.sv | 92 +++++++++
 1 files changed

// File: rtl/sig_conditioner.sv
// Front-end conditioner for the frequency meter: synchronises the raw sig pin,
// rejects short pulses, emits rise/fall strobes and flags loss of signal.
module sig_conditioner #(
    parameter int SYNC_STAGES = 2,      // 2..4
    parameter int FILT_LEN    = 8,      // 1..15
    parameter int TO_TICKS    = 50000,
    parameter int TO_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       sig,
    output logic       sig_clean,
    output logic       rise,
    output logic       fall,
    output logic       sig_lost,
    output logic [7:0] glitch_cnt
);

    localparam logic [3:0]      FILT_LAST = 4'(FILT_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_TICKS - 1);
    localparam logic [TO_W-1:0] TCNT_ONE  = TO_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [3:0]             fcnt;
    logic [TO_W-1:0]        tcnt;
    logic                   differ;
    logic                   accept;
    logic                   abort;

    assign sync   = sync_q[SYNC_STAGES-1];
    assign differ = (sync != sig_clean);
    assign accept = differ && (fcnt == FILT_LAST);
    // A change that had started counting and then fell back is a rejected pulse.
    assign abort  = !differ && (fcnt != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_clean <= 1'b0;
            fcnt      <= 4'd0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            // Strobes are registered with sig_clean so they coincide with its new level.
            rise <= accept && sync;
            fall <= accept && !sync;
            if (!differ) begin
                fcnt <= 4'd0;
            end else if (accept) begin
                sig_clean <= sync;
                fcnt      <= 4'd0;
            end else begin
                fcnt <= fcnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= 8'd0;
        end else if (abort && (glitch_cnt != 8'hff)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end

    // A rise restarts the timeout even when a tick lands in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt     <= '0;
            sig_lost <= 1'b0;
        end else if (rise) begin
            tcnt     <= '0;
            sig_lost <= 1'b0;
        end else if (tick) begin
            if (tcnt == TO_LAST) begin
                sig_lost <= 1'b1;
            end else begin
                tcnt <= tcnt + TCNT_ONE;
            end
        end
    end

endmodule
